// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the button-driven LED capture controller.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS0   = 2'd1,
    WAIT_REL = 2'd2
  } state_e;

  localparam int unsigned LED_W = 5;

endpackage

// File: rtl/led_capture_ctrl_if.sv
// Board-facing bundle: raw active-low buttons in, LED capture register out.
interface led_capture_ctrl_if;
  import led_ctrl_pkg::*;

  logic [1:0]       btn;
  logic [LED_W-1:0] LED;

  modport master (output btn, input  LED);
  modport slave  (input  btn, output LED);
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability-count debouncer for one active-low button.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 270000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic pressed
);

  localparam int unsigned     CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          p_q, p_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          s;

  assign s       = ~sync2_q;
  assign pressed = p_q;

  // Level flips on the clock the count would reach DEBOUNCE_CYCLES.
  always_comb begin
    p_d   = p_q;
    cnt_d = '0;
    if (s != p_q) begin
      if (cnt_q == CNT_LAST) begin
        p_d = s;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      p_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/led_capture_ctrl.sv
// Capture controller: button 0 strobes the level of button 1 into a 5-bit LED
// shift register; holding both buttons long enough clears it.
module led_capture_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned HOLD_CYCLES     = 27000000
) (
  input  logic               clk,
  input  logic               rst,
  led_capture_ctrl_if.slave  bus
);

  localparam int unsigned   HW        = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic             p0, p1;
  logic             p0_prev_q;
  state_e           state_q, state_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             bit_q, bit_d;
  logic [LED_W-1:0] led_q, led_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db0 (
    .clk     (clk),
    .rst     (rst),
    .btn_n   (bus.btn[0]),
    .pressed (p0)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db1 (
    .clk     (clk),
    .rst     (rst),
    .btn_n   (bus.btn[1]),
    .pressed (p1)
  );

  assign bus.LED = led_q;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    bit_d   = bit_q;
    led_d   = led_q;
    unique case (state_q)
      IDLE: begin
        if (p0 && !p0_prev_q) begin
          bit_d   = p1;
          hold_d  = '0;
          state_d = PRESS0;
        end
      end
      PRESS0: begin
        if (!p0) begin
          led_d   = {led_q[LED_W-2:0], bit_q};
          state_d = IDLE;
        end else if (p1) begin
          // Clear fires on the HOLD_CYCLES-th both-held clock, so the
          // counter never needs to advance past HOLD_CYCLES-1.
          if (hold_q == HOLD_LAST) begin
            led_d   = '0;
            state_d = WAIT_REL;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end else begin
          hold_d = '0;
        end
      end
      WAIT_REL: begin
        if (!p0 && !p1) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      bit_q     <= 1'b0;
      led_q     <= '0;
      p0_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      bit_q     <= bit_d;
      led_q     <= led_d;
      p0_prev_q <= p0;
    end
  end

endmodule
